// File: rtl/line_fetch_engine_pkg.sv
// Shared types and defaults for the line fetch engine: FSM states,
// default geometry, and the words-per-line rule.
package line_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_MEM,
    REQ,
    WRITE,
    DONE
  } state_e;

  localparam int DEF_WORD_W   = 128;
  localparam int DEF_PIX_W    = 8;
  localparam int DEF_ADDR_W   = 22;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_TOTAL  = 525;

  // A doubled (320-wide) source line needs half the words of a native line.
  function automatic int words_per_line(input int h_active, input int ppw, input logic scale);
    return scale ? h_active / (2 * ppw) : h_active / ppw;
  endfunction

endpackage

// File: rtl/line_fetch_engine_if.sv
// Word-read memory bus: request/address out, wait/ack/data back.
interface line_fetch_engine_if
  import line_fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int WORD_W = DEF_WORD_W
);
  logic              mem_wait;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [WORD_W-1:0] mem_data;

  modport master (input mem_wait, mem_ack, mem_data, output mem_rd, mem_addr);
  modport slave  (output mem_wait, mem_ack, mem_data, input mem_rd, mem_addr);
endinterface

// File: rtl/line_fetch_engine_ram.sv
// Two-bank line buffer: one write port, one read port with a one-clock
// registered read.
module line_ram #(
  parameter int DEPTH  = 80,
  parameter int WORD_W = 128,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [WORD_W-1:0] rdata_o
);
  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/line_fetch_engine.sv
// Prefetches the next video line from word memory into a ping-pong line
// buffer and streams palette indices for the current beam position.
module line_fetch_engine
  import line_fetch_pkg::*;
#(
  parameter int WORD_W   = DEF_WORD_W,
  parameter int PIX_W    = DEF_PIX_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_TOTAL  = DEF_V_TOTAL
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [9:0]          draw_x,
  input  logic [9:0]          draw_y,
  input  logic                blank,
  input  logic                new_frame,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                scale2x,
  line_fetch_engine_if.master mem,
  output logic [PIX_W-1:0]    pix_index,
  output logic                pix_valid,
  output logic                busy,
  output logic                underrun
);
  localparam int PPW       = WORD_W / PIX_W;
  localparam int WPL_MAX   = H_ACTIVE / PPW;
  localparam int IDX_W     = $clog2(WPL_MAX);
  localparam int RAM_DEPTH = 2 * WPL_MAX;
  localparam int RAM_AW    = $clog2(RAM_DEPTH);
  localparam int SLOT_W    = $clog2(PPW);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [9:0]        tgt_q, tgt_d, pend_tgt_q, pend_tgt_d, y_q;
  logic              abort_q, abort_d, pend_go_q, pend_go_d;
  logic [1:0]        ready_q, ready_d;
  logic              underrun_q, scale_lat_q;
  logic [ADDR_W-1:0] base_lat_q, addr_q, addr_d;
  logic [WORD_W-1:0] data_q, rd_data;
  logic [SLOT_W-1:0] slot1_q;
  logic              blank1_q, rdy1_q, pix_valid_q;
  logic [PIX_W-1:0]  pix_q;

  logic              line_ev, start;
  logic [9:0]        target, src_d, col;
  logic [ADDR_W-1:0] wpl_a;
  logic [IDX_W-1:0]  wpl_m1;

  assign line_ev = (draw_y != y_q);
  assign target  = (draw_y == 10'(V_TOTAL - 1)) ? 10'd0 : draw_y + 10'd1;
  assign start   = line_ev && (target < 10'(V_ACTIVE));
  assign wpl_a   = ADDR_W'(words_per_line(H_ACTIVE, PPW, scale_lat_q));
  assign wpl_m1  = IDX_W'(words_per_line(H_ACTIVE, PPW, scale_lat_q) - 1);
  assign col     = scale_lat_q ? {1'b0, draw_x[9:1]} : draw_x;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tgt_d      = tgt_q;
    abort_d    = abort_q;
    pend_tgt_d = pend_tgt_q;
    pend_go_d  = pend_go_q;
    ready_d    = ready_q;
    src_d      = '0;
    addr_d     = addr_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT_MEM;
          idx_d   = '0;
          tgt_d   = target;
        end
      end
      WAIT_MEM: begin
        if (line_ev) begin
          state_d = start ? WAIT_MEM : IDLE;
          idx_d   = '0;
          tgt_d   = target;
        end else if (!mem.mem_wait) begin
          state_d = REQ;
        end
      end
      REQ: begin
        // An outstanding request cannot be withdrawn: remember the new line
        // and restart only once the in-flight word has been acknowledged.
        if (line_ev) begin
          abort_d    = 1'b1;
          pend_tgt_d = target;
          pend_go_d  = start;
        end
        if (mem.mem_ack) begin
          if (abort_d) begin
            abort_d = 1'b0;
            idx_d   = '0;
            tgt_d   = pend_tgt_d;
            state_d = pend_go_d ? WAIT_MEM : IDLE;
          end else begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (line_ev) begin
          state_d = start ? WAIT_MEM : IDLE;
          idx_d   = '0;
          tgt_d   = target;
        end else if (idx_q == wpl_m1) begin
          state_d = DONE;
        end else begin
          state_d = WAIT_MEM;
          idx_d   = idx_q + 1'b1;
        end
      end
      DONE: begin
        ready_d[tgt_q[0]] = 1'b1;
        state_d = IDLE;
        if (start) begin
          state_d = WAIT_MEM;
          idx_d   = '0;
          tgt_d   = target;
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) ready_d[target[0]] = 1'b0;
    src_d = scale_lat_q ? (tgt_d >> 1) : tgt_d;
    if (state_d == WAIT_MEM)
      addr_d = base_lat_q + ADDR_W'(src_d) * wpl_a + ADDR_W'(idx_d);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      tgt_q       <= '0;
      pend_tgt_q  <= '0;
      abort_q     <= 1'b0;
      pend_go_q   <= 1'b0;
      ready_q     <= '0;
      addr_q      <= '0;
      y_q         <= '0;
      underrun_q  <= 1'b0;
      base_lat_q  <= '0;
      scale_lat_q <= 1'b0;
      data_q      <= '0;
      slot1_q     <= '0;
      blank1_q    <= 1'b0;
      rdy1_q      <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_q       <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tgt_q      <= tgt_d;
      pend_tgt_q <= pend_tgt_d;
      abort_q    <= abort_d;
      pend_go_q  <= pend_go_d;
      ready_q    <= ready_d;
      addr_q     <= addr_d;
      y_q        <= draw_y;
      underrun_q <= (underrun_q && !new_frame) ||
                    (line_ev && (draw_y < 10'(V_ACTIVE)) && !ready_q[draw_y[0]]);
      if (new_frame) begin
        base_lat_q  <= base_addr;
        scale_lat_q <= scale2x;
      end
      if (state_q == REQ && mem.mem_ack) data_q <= mem.mem_data;
      slot1_q     <= col[SLOT_W-1:0];
      blank1_q    <= blank;
      rdy1_q      <= ready_q[draw_y[0]];
      pix_valid_q <= blank1_q;
      pix_q       <= (blank1_q && rdy1_q) ? rd_data[PIX_W*slot1_q +: PIX_W] : '0;
    end
  end

  line_ram #(.DEPTH(RAM_DEPTH), .WORD_W(WORD_W), .AW(RAM_AW)) u_ram (
    .clock   (clock),
    .we_i    (state_q == WRITE),
    .waddr_i ((tgt_q[0] ? RAM_AW'(WPL_MAX) : RAM_AW'(0)) + RAM_AW'(idx_q)),
    .wdata_i (data_q),
    .raddr_i ((draw_y[0] ? RAM_AW'(WPL_MAX) : RAM_AW'(0)) + RAM_AW'(col >> SLOT_W)),
    .rdata_o (rd_data)
  );

  assign mem.mem_rd   = (state_q == REQ);
  assign mem.mem_addr = addr_q;
  assign busy         = (state_q == WAIT_MEM) || (state_q == REQ) || (state_q == WRITE);
  assign underrun     = underrun_q;
  assign pix_index    = pix_q;
  assign pix_valid    = pix_valid_q;
endmodule

// File: tb/tb_line_fetch_engine.sv
// Directed sequence with randomized memory timing and pixel positions,
// checked against a line-level model of fetches, banks and display.
module tb_line_fetch_engine;
  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [9:0]  draw_x = '0, draw_y = '0;
  logic        blank = 1'b0, new_frame = 1'b0, scale2x = 1'b0;
  logic [21:0] base_addr = '0;
  logic [7:0]  pix_index;
  logic        pix_valid, busy, underrun;

  logic         ack_en = 1'b1, rand_wait = 1'b0, wait_force = 1'b0, wait_rnd = 1'b0;
  logic         resp_ack = 1'b0, stray_ack = 1'b0;
  logic [127:0] resp_data = '0;
  logic [21:0]  log_q[$];
  int           stab_err = 0, gap_err = 0;

  int total = 0, passed = 0, fails = 0;

  // model state
  bit          m_ready[2];
  logic [21:0] m_bank_addr0[2];
  logic [21:0] m_base = '0;
  bit          m_scale = 0, m_under = 0;
  bit          f_go = 0;
  int          f_tgt = 0, f_w = 0;
  logic [21:0] f_addr0 = '0;

  line_fetch_engine_if #(.ADDR_W(22), .WORD_W(128)) mif ();

  assign mif.mem_wait = wait_force | (rand_wait & wait_rnd);
  assign mif.mem_ack  = resp_ack | stray_ack;
  assign mif.mem_data = stray_ack ? {4{32'hDEADBEEF}} : resp_data;

  line_fetch_engine dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .draw_x    (draw_x),
    .draw_y    (draw_y),
    .blank     (blank),
    .new_frame (new_frame),
    .base_addr (base_addr),
    .scale2x   (scale2x),
    .mem       (mif.master),
    .pix_index (pix_index),
    .pix_valid (pix_valid),
    .busy      (busy),
    .underrun  (underrun)
  );

  initial forever #5 clock = ~clock;

  function automatic logic [127:0] word_of(input logic [21:0] a);
    logic [31:0] x;
    x = {10'd0, a};
    return {x * 32'h9E3779B1, x ^ 32'h5A5A1234, ~x * 32'd7, x + 32'h13579BDF};
  endfunction

  // Memory model: acks after a random delay, logs acknowledged addresses.
  initial begin
    int          dly;
    logic        prev_rd;
    logic [21:0] prev_addr;
    dly = 0; prev_rd = 0; prev_addr = '0;
    forever begin
      @(negedge clock);
      wait_rnd = ($urandom_range(0, 2) == 0);
      if (resp_ack) begin
        resp_ack = 1'b0;
        if (mif.mem_rd) gap_err++;
      end else if (mif.mem_rd) begin
        if (prev_rd && mif.mem_addr != prev_addr) stab_err++;
        if (ack_en) begin
          if (dly == 0) begin
            resp_ack  = 1'b1;
            resp_data = word_of(mif.mem_addr);
            log_q.push_back(mif.mem_addr);
            dly = $urandom_range(0, 3);
          end else begin
            dly--;
          end
        end
      end
      prev_rd   = mif.mem_rd;
      prev_addr = mif.mem_addr;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic line_event(input int y);
    int tgt, src;
    @(negedge clock);
    draw_y = 10'(y);
    if (y < 480 && !m_ready[y % 2]) m_under = 1;
    tgt = (y == 524) ? 0 : y + 1;
    if (tgt < 480) begin
      m_ready[tgt % 2] = 0;
      f_go    = 1;
      f_tgt   = tgt;
      f_w     = m_scale ? 20 : 40;
      src     = m_scale ? tgt / 2 : tgt;
      f_addr0 = 22'(int'(m_base) + src * f_w);
    end else begin
      f_go = 0;
    end
    @(negedge clock);
    check("underrun_on_line", underrun, m_under);
    check("busy_on_line", busy, f_go);
  endtask

  task automatic fetch_complete();
    int n;
    logic [21:0] a;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check("fetch_timeout", busy, 1'b0);
    check("req_count", log_q.size(), f_w);
    for (int i = 0; i < f_w; i++) begin
      a = (log_q.size() > 0) ? log_q.pop_front() : '1;
      check("req_addr", a, 22'(f_addr0 + 22'(i)));
    end
    log_q.delete();
    @(negedge clock);
    m_ready[f_tgt % 2]      = 1;
    m_bank_addr0[f_tgt % 2] = f_addr0;
    $display("fetch line %0d: %0d words from %0h", f_tgt, f_w, f_addr0);
  endtask

  task automatic do_line(input int y);
    line_event(y);
    fetch_complete();
  endtask

  task automatic frame_start(input logic [21:0] b, input bit s);
    @(negedge clock);
    base_addr = b;
    scale2x   = s;
    new_frame = 1'b1;
    @(negedge clock);
    new_frame = 1'b0;
    m_base = b; m_scale = s; m_under = 0;
    check("underrun_clear", underrun, 1'b0);
  endtask

  task automatic disp_check(input int n, input int first_x, input string tag);
    logic [8:0]   q[$];
    logic [127:0] w;
    int x, c, bank;
    bit b;
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clock);
      if (i >= 2) check(tag, {pix_valid, pix_index}, q.pop_front());
      if (i < n) begin
        x = (i == 0 && first_x >= 0) ? first_x : $urandom_range(0, 639);
        b = ($urandom_range(0, 4) != 0);
        draw_x = 10'(x);
        blank  = b;
        bank = draw_y[0];
        c = m_scale ? x / 2 : x;
        if (!b) q.push_back(9'd0);
        else if (!m_ready[bank]) q.push_back({1'b1, 8'd0});
        else begin
          w = word_of(22'(m_bank_addr0[bank] + 22'(c / 16)));
          q.push_back({1'b1, w[8 * (c % 16) +: 8]});
        end
      end else begin
        blank = 1'b0;
      end
    end
  endtask

  initial begin
    int          n, bad;
    bit          got;
    logic [21:0] disc_addr, a;

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_mem_rd", mif.mem_rd, 1'b0);
    check("rst_mem_addr", mif.mem_addr, 22'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_pix", {pix_valid, pix_index}, 9'd0);
    reset_n = 1'b1;

    frame_start(22'h100000, 0);
    do_line(9);                     // bank 1 never filled: underrun expected
    frame_start(22'h100000, 0);
    do_line(10);                    // line 11 at 0x1001B8..0x1001DF
    disp_check(20, -1, "pix_native");

    rand_wait = 1'b1;
    do_line(11);
    rand_wait = 1'b0;
    disp_check(12, -1, "pix_randwait");

    base_addr = 22'h200000;         // no new_frame yet: old base must be used
    do_line(12);
    frame_start(22'h200000, 1);
    do_line(13);
    do_line(20);
    do_line(21);
    disp_check(16, 5, "pix_scaled");

    wait_force = 1'b1;
    line_event(22);
    bad = 0;
    repeat (100) begin
      @(negedge clock);
      if (mif.mem_rd !== 1'b0 || busy !== 1'b1) bad++;
    end
    check("wait_hold", bad, 0);
    wait_force = 1'b0;
    got = 0;
    repeat (2) begin
      @(negedge clock);
      if (mif.mem_rd) got = 1;
    end
    check("wait_release", got, 1'b1);
    fetch_complete();

    ack_en = 1'b0;
    line_event(23);
    n = 0;
    while (!mif.mem_rd && n < 50) begin @(negedge clock); n++; end
    check("stall_req", mif.mem_rd, 1'b1);
    disc_addr = f_addr0;
    line_event(24);
    disp_check(12, -1, "pix_underrun");
    ack_en = 1'b1;
    n = 0;
    while (log_q.size() == 0 && n < 50) begin @(negedge clock); n++; end
    a = (log_q.size() > 0) ? log_q.pop_front() : '1;
    check("discard_addr", a, disc_addr);
    fetch_complete();
    frame_start(22'h200000, 1);

    do_line(29);
    ack_en = 1'b0;
    line_event(30);
    n = 0;
    while (!mif.mem_rd && n < 50) begin @(negedge clock); n++; end
    check("stall_req2", mif.mem_rd, 1'b1);
    reset_n = 1'b0;
    #1;
    check("arst_mem_rd", mif.mem_rd, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_addr", mif.mem_addr, 22'd0);
    check("arst_underrun", underrun, 1'b0);
    m_ready[0] = 0; m_ready[1] = 0;
    m_base = '0; m_scale = 0; m_under = 0;
    draw_y = '0;
    @(negedge clock); stray_ack = 1'b1;
    @(negedge clock); stray_ack = 1'b0; reset_n = 1'b1;
    @(negedge clock); stray_ack = 1'b1;
    @(negedge clock); stray_ack = 1'b0;
    repeat (3) @(negedge clock);
    check("stray_busy", busy, 1'b0);
    check("stray_rd", mif.mem_rd, 1'b0);
    check("stray_log", log_q.size(), 0);
    disp_check(12, -1, "pix_after_reset");
    ack_en = 1'b1;
    frame_start(22'h100000, 0);
    do_line(1);

    check("addr_stable", stab_err, 0);
    check("rd_gap", gap_err, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
